// File: rtl/pio_poll_pkg.sv
// Shared definitions for the PIO poll master.
// Holds the FSM state encoding and the default register map / poll interval
// used as parameter defaults by pio_poll_master.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CMP   = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam int unsigned DEF_POLL_DIV = 50000;
  localparam logic [31:0] DEF_SW_ADDR  = 32'h0000_1000;
  localparam logic [31:0] DEF_LED_ADDR = 32'h0000_1010;

endpackage

// File: rtl/pio_poll_master_if.sv
// Avalon-MM bus between the poll master and the PIO slave.
// Signals:
//   avm_address     master -> slave  32-bit byte address
//   avm_read        master -> slave  read request
//   avm_write       master -> slave  write request
//   avm_writedata   master -> slave  32-bit write data
//   avm_readdata    slave  -> master 32-bit read data (valid when read && !waitrequest)
//   avm_waitrequest slave  -> master stall
interface pio_poll_master_if;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/poll_timer.sv
// Poll interval down-counter.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset (counter -> DIV-1)
//   load_i   reload counter with DIV-1 (has priority over en_i)
//   en_i     decrement by one per cycle; the counter parks at zero
//   zero_o   counter is zero
module poll_timer #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int unsigned   CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pio_poll_master.sv
// Periodically reads an 8-bit switch PIO and mirrors the value to an LED PIO
// whenever it changes (or on the first poll after reset).
// Parameters:
//   POLL_DIV  clk cycles spent in IDLE between poll starts (>= 4)
//   SW_ADDR   byte address of the switch PIO data register
//   LED_ADDR  byte address of the LED PIO data register
// Ports:
//   clk       clock
//   reset_n   asynchronous active-low reset
//   enable    polling enable, only looked at while idle
//   avm       Avalon-MM master bus (pio_poll_master_if.master)
//   sw_value  last sampled switch value
//   change    one-cycle pulse after a new value has been written to the LEDs
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int unsigned POLL_DIV = DEF_POLL_DIV,
  parameter logic [31:0] SW_ADDR  = DEF_SW_ADDR,
  parameter logic [31:0] LED_ADDR = DEF_LED_ADDR
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  pio_poll_master_if.master         avm,
  output logic [7:0]                sw_value,
  output logic                      change
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic        read_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [7:0]  rd_q;
  logic [7:0]  sw_q;
  logic        valid_q;
  logic        chg_q;

  logic tmr_zero;
  logic tmr_load;
  logic tmr_en;

  // Only the low byte of the switch register carries data.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^avm.avm_readdata[31:8];

  // The interval only advances while idle and enabled; reloading on the
  // IDLE->READ transition makes the period POLL_DIV plus transfer cycles.
  assign tmr_en   = (state_q == ST_IDLE) && enable;
  assign tmr_load = tmr_en && tmr_zero;

  poll_timer #(
    .DIV (POLL_DIV)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (tmr_load),
    .en_i    (tmr_en),
    .zero_o  (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      sw_q    <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable && tmr_zero) begin
            read_q  <= 1'b1;
            addr_q  <= SW_ADDR;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (!avm.avm_waitrequest) begin
            rd_q    <= avm.avm_readdata[7:0];
            read_q  <= 1'b0;
            state_q <= ST_CMP;
          end
        end
        ST_CMP: begin
          // valid_q forces the very first poll to refresh the LEDs.
          if ((rd_q != sw_q) || !valid_q) begin
            sw_q    <= rd_q;
            valid_q <= 1'b1;
            write_q <= 1'b1;
            addr_q  <= LED_ADDR;
            wdata_q <= {24'b0, rd_q};
            state_q <= ST_WRITE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (!avm.avm_waitrequest) begin
            write_q <= 1'b0;
            chg_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_writedata = wdata_q;
  assign sw_value          = sw_q;
  assign change            = chg_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Self-checking bench for pio_poll_master: directed stimulus pushes expected
// bus transactions and change values into queues; a negedge monitor pops and
// compares them as the DUT presents accepted transfers and change pulses.
module tb_pio_poll_master;

  localparam int unsigned POLL_DIV = 4;
  localparam logic [31:0] SW       = 32'h0000_1000;
  localparam logic [31:0] LED      = 32'h0000_1010;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic [7:0] sw_value;
  logic       change;

  pio_poll_master_if bus ();

  pio_poll_master #(
    .POLL_DIV (POLL_DIV),
    .SW_ADDR  (SW),
    .LED_ADDR (LED)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .avm      (bus),
    .sw_value (sw_value),
    .change   (change)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] chg_q[$];
  int checks   = 0;
  int errors   = 0;
  int n_change = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read();
    txn_t t;
    t.is_wr = 1'b0; t.addr = SW; t.data = '0;
    exp_q.push_back(t);
  endtask

  task automatic push_write(input logic [7:0] v);
    txn_t t;
    t.is_wr = 1'b1; t.addr = LED; t.data = {24'b0, v};
    exp_q.push_back(t);
    chg_q.push_back(v);
  endtask

  task automatic wait_for(input bit wr, input string name, input int budget);
    int n;
    n = 0;
    while (!(wr ? bus.avm_write : bus.avm_read) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!(wr ? bus.avm_write : bus.avm_read)) begin
      errors++;
      $display("FAIL %s: request not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || chg_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || chg_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d txns and %0d change pulses still outstanding, required 0",
               name, exp_q.size(), chg_q.size());
      exp_q.delete();
      chg_q.delete();
    end
  endtask

  // Monitor: compares accepted transfers and change pulses with the queues.
  always @(negedge clk) begin
    txn_t t;
    if (reset_n) begin
      if (bus.avm_read && bus.avm_write) begin
        checks++;
        errors++;
        $display("FAIL rw_overlap: read and write both high, required exclusive");
      end
      if ((bus.avm_read || bus.avm_write) && !bus.avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got write=%0b addr %h, required no transfer",
                   bus.avm_write, bus.avm_address);
        end else begin
          t = exp_q.pop_front();
          check32("txn_kind", {31'b0, bus.avm_write}, {31'b0, t.is_wr});
          check32("txn_addr", bus.avm_address, t.addr);
          if (t.is_wr) check32("txn_wdata", bus.avm_writedata, t.data);
        end
      end
      if (change) begin
        n_change++;
        if (chg_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got change with sw_value %h, required no pulse", sw_value);
        end else begin
          check32("sw_value_on_change", {24'b0, sw_value}, {24'b0, chg_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    bus.avm_readdata    = '0;
    bus.avm_waitrequest = 1'b0;

    // Reset state
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) tick();
    check32("rst_read",  {31'b0, bus.avm_read},  32'd0);
    check32("rst_write", {31'b0, bus.avm_write}, 32'd0);
    check32("rst_addr",  bus.avm_address,        32'd0);
    check32("rst_wdata", bus.avm_writedata,      32'd0);
    check32("rst_sw",    {24'b0, sw_value},      32'd0);
    check32("rst_chg",   {31'b0, change},        32'd0);
    reset_n = 1'b1;
    tick();

    // First poll: A5, always written
    bus.avm_readdata = 32'h0000_00A5;
    push_read();
    push_write(8'hA5);
    enable = 1'b1;
    wait_for(1'b0, "t1_read", 20);
    n = 0;
    while (!change && n < 10) begin
      tick();
      n++;
    end
    check32("t1_latency", n, 32'd3);
    wait_drain("t1_drain", 20);
    enable = 1'b0;
    check32("t1_sw", {24'b0, sw_value}, 32'h0000_00A5);

    // Same value again: read only
    c0 = n_change;
    push_read();
    enable = 1'b1;
    wait_for(1'b0, "t2_read", 20);
    enable = 1'b0;
    wait_drain("t2_drain", 20);
    repeat (3) tick();
    check32("t2_no_change", n_change, c0);
    check32("t2_no_write", {31'b0, bus.avm_write}, 32'd0);
    check32("t2_sw", {24'b0, sw_value}, 32'h0000_00A5);

    // Read stalled 5 cycles; upper readdata bits must be dropped
    bus.avm_waitrequest = 1'b1;
    bus.avm_readdata    = 32'h0000_0011;
    push_read();
    push_write(8'h3C);
    enable = 1'b1;
    wait_for(1'b0, "t3_read", 20);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check32("t3_hold_read", {31'b0, bus.avm_read}, 32'd1);
      check32("t3_hold_addr", bus.avm_address, SW);
      tick();
    end
    check32("t3_hold_read_last", {31'b0, bus.avm_read}, 32'd1);
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = 32'hFFFF_FF3C;
    wait_drain("t3_drain", 20);
    check32("t3_sw", {24'b0, sw_value}, 32'h0000_003C);

    // Enable dropped during a stalled write
    bus.avm_readdata = 32'h0000_005A;
    push_read();
    push_write(8'h5A);
    enable = 1'b1;
    wait_for(1'b1, "t4_write", 30);
    bus.avm_waitrequest = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check32("t4_hold_write", {31'b0, bus.avm_write}, 32'd1);
      check32("t4_hold_wdata", bus.avm_writedata, 32'h0000_005A);
    end
    bus.avm_waitrequest = 1'b0;
    wait_drain("t4_drain", 20);
    c0 = n_change;
    repeat (20) tick();
    check32("t4_idle_read", {31'b0, bus.avm_read}, 32'd0);
    check32("t4_idle_change", n_change, c0);

    // Reset mid-read; next poll must write even with unchanged data
    bus.avm_waitrequest = 1'b1;
    push_read();
    enable = 1'b1;
    wait_for(1'b0, "t5_read", 20);
    reset_n = 1'b0;
    #1;
    check32("t5_async_read", {31'b0, bus.avm_read}, 32'd0);
    exp_q.delete();
    chg_q.delete();
    check32("t5_rst_sw", {24'b0, sw_value}, 32'd0);
    tick();
    tick();
    bus.avm_waitrequest = 1'b0;
    push_read();
    push_write(8'h5A);
    reset_n = 1'b1;
    wait_drain("t5_drain", 30);
    enable = 1'b0;
    check32("t5_sw", {24'b0, sw_value}, 32'h0000_005A);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
